reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised successor to the board's power-on reset / clock-divider glue.
- Holds every clock domain in reset for a power-on window, then waits for a filtered PLL lock.
- Releases NUM_DOMAINS domain resets one after another with a programmable gap.
- After release, monitors lock loss and a debounced soft-reset request. Sits in top between the PLL/oscillator and all downstream blocks (LCD, chip).

Parameters:
- POR_CYCLES, 1562500: cycles of the power-on hold window after reset deassertion; must be ≥1.
- NUM_DOMAINS, 3: number of domain reset outputs; ≥1.
- STAGE_GAP, 16: cycles between successive domain releases; ≥1.
- LOCK_FILTER, 256: consecutive synchronised-locked cycles required before release; ≥1.
- DEBOUNCE_CYCLES, 65536: consecutive cycles soft_rst must be high to register; ≥1.

Ports:
- clk, input, 1: always-running reference clock (oscillator, not PLL output).
- reset, input, 1: asynchronous, active-high; clock clk.
- pll_locked, input, 1: PLL LOCK, asynchronous to clk.
- soft_rst, input, 1: raw button/user reset request, asynchronous, active-high.
- clr_lock_lost, input, 1: synchronous pulse clearing the lock_lost flag.
- domain_reset, output, NUM_DOMAINS: per-domain active-high reset; bit 0 released first.
- all_ready, output, 1: high only in RUN.
- state, output, 2: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- lock_lost, output, 1: sticky; set on lock loss after leaving WAIT_LOCK.

Behaviour:
- Reset values (async): domain_reset all 1; all_ready 0; state HOLD; lock_lost 0; POR counter = POR_CYCLES-1; lock, gap, debounce and stage counters 0; synchroniser flops 0.
- pll_locked and soft_rst each pass through a 2-flop synchroniser (locked_s, soft_s). This adds 2 cycles of latency. All decisions below use the synchronised values.
- Counter widths: $clog2(max value + 1); no counter wraps; each saturates or reloads as stated.
- HOLD:
  - Counter decrements each cycle. The edge where it equals 0 moves to WAIT_LOCK, so HOLD lasts exactly POR_CYCLES cycles.
  - domain_reset all 1.
- WAIT_LOCK:
  - lock_cnt increments while locked_s=1 and clears to 0 when locked_s=0.
  - On the edge where locked_s=1 and lock_cnt==LOCK_FILTER-1, go to RELEASE and clear domain_reset[0] on that same edge.
- RELEASE:
  - gap_cnt counts 0..STAGE_GAP-1. On wrap, clear the next domain_reset bit (index via stage counter).
  - Domain i deasserts exactly i*STAGE_GAP cycles after domain 0.
  - The edge clearing bit NUM_DOMAINS-1 also sets state RUN and all_ready=1.
  - With NUM_DOMAINS=1, WAIT_LOCK goes directly to RUN.
- RUN: outputs hold; domain_reset all 0.
- Lock loss (locked_s=0 in RELEASE or RUN):
  - Next edge sets domain_reset all 1, all_ready 0, lock_lost 1, state WAIT_LOCK.
  - lock_cnt and stage counters clear.
- Soft reset:
  - deb_cnt increments while soft_s=1, clears when soft_s=0, and saturates at DEBOUNCE_CYCLES-1.
  - When soft_s=1 and deb_cnt==DEBOUNCE_CYCLES-1 in a state other than HOLD, go to HOLD: reload POR counter, set domain_reset all 1, all_ready 0.
  - A held button does not retrigger until soft_s returns to 0, tracked by an armed flag.
  - lock_lost is not affected by soft reset.
- Priority on the same edge: async reset > soft-reset trigger > lock loss > normal progression.
- lock_lost: set has priority over clr_lock_lost in the same cycle; it is cleared only by clr_lock_lost or reset.
- Glitch rules:
  - locked_s pulsing high for fewer than LOCK_FILTER cycles never releases any domain.
  - soft_s pulses shorter than DEBOUNCE_CYCLES are ignored.
- Async reset mid-operation returns to the reset values immediately, with no clock needed. Deassertion is assumed synchronous to clk, handled by upstream por logic.
- domain_reset bits are registered outputs, glitch-free.

Test Plan (POR_CYCLES=16, NUM_DOMAINS=3, STAGE_GAP=4, LOCK_FILTER=8, DEBOUNCE_CYCLES=4):
- Boot with pll_locked=1 throughout:
  - state=HOLD for 16 cycles after reset falls, then WAIT_LOCK.
  - domain_reset 111→110 at edge E, →100 at E+4, →000 at E+8 with all_ready=1 and state=3.
- Lock glitch: pll_locked high 5 cycles, low 1, then high:
  - lock_cnt restarts; release occurs 8 synchronised-high cycles after the final rise.
  - domain_reset stays 111 before that.
- Lock loss in RUN: drop pll_locked:
  - 3 cycles later (2 sync + 1) domain_reset=111, all_ready=0, lock_lost=1, state=1.
  - Relock repeats the staggered release.
  - clr_lock_lost pulse then clears lock_lost.
- Soft reset: 3-cycle soft_rst pulse is ignored. A 10-cycle pulse in RUN:
  - state=HOLD 6 cycles after the rise (2 sync + 4 debounce); all domains reset.
  - The 16-cycle HOLD runs, and there is no second trigger while the button stays held.
- Simultaneous: soft-reset trigger and lock loss on the same edge → state=HOLD, lock_lost=1.
- Async reset asserted mid-RELEASE (domain_reset=100) → outputs immediately 111, state=0, all_ready=0, lock_lost=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset sequencer. It holds every clock domain in reset for a power-on window,
// waits for a filtered PLL lock, then releases the domains one after another.
`timescale 1ns/1ps
module reset_sequencer #(
    parameter int POR_CYCLES      = 1562500,
    parameter int NUM_DOMAINS     = 3,
    parameter int STAGE_GAP       = 16,
    parameter int LOCK_FILTER     = 256,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   soft_rst,
    input  logic                   clr_lock_lost,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_ready,
    output logic [1:0]             state,
    output logic                   lock_lost
);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int POR_W   = (POR_CYCLES > 1)      ? $clog2(POR_CYCLES)      : 1;
    localparam int LOCK_W  = (LOCK_FILTER > 1)     ? $clog2(LOCK_FILTER)     : 1;
    localparam int GAP_W   = (STAGE_GAP > 1)       ? $clog2(STAGE_GAP)       : 1;
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int STAGE_W = (NUM_DOMAINS > 1)     ? $clog2(NUM_DOMAINS)     : 1;

    localparam logic [POR_W-1:0]   POR_MAX    = POR_W'(POR_CYCLES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_MAX   = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(STAGE_GAP - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_DOMAINS - 1);

    logic lock_meta, locked_s, soft_meta, soft_s;

    state_t                 state_q, state_n;
    logic [POR_W-1:0]       por_cnt, por_n;
    logic [LOCK_W-1:0]      lock_cnt, lock_n;
    logic [GAP_W-1:0]       gap_cnt, gap_n;
    logic [DEB_W-1:0]       deb_cnt, deb_n;
    logic [STAGE_W-1:0]     stage_cnt, stage_n;
    logic [NUM_DOMAINS-1:0] dom_q, dom_n;
    logic                   lost_q, lost_n;
    logic                   armed_q, armed_n;
    logic                   soft_trig, lock_drop;

    // Both asynchronous inputs go through two flops before any decision uses them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
            soft_meta <= 1'b0;
            soft_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
            soft_meta <= soft_rst;
            soft_s    <= soft_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            por_cnt   <= POR_MAX;
            lock_cnt  <= '0;
            gap_cnt   <= '0;
            deb_cnt   <= '0;
            stage_cnt <= '0;
            dom_q     <= '1;
            lost_q    <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_n;
            por_cnt   <= por_n;
            lock_cnt  <= lock_n;
            gap_cnt   <= gap_n;
            deb_cnt   <= deb_n;
            stage_cnt <= stage_n;
            dom_q     <= dom_n;
            lost_q    <= lost_n;
            armed_q   <= armed_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n   = state_q;
        por_n     = por_cnt;
        lock_n    = lock_cnt;
        gap_n     = gap_cnt;
        stage_n   = stage_cnt;
        dom_n     = dom_q;
        lost_n    = lost_q;
        armed_n   = armed_q;
        deb_n     = deb_cnt;

        soft_trig = soft_s && armed_q && (deb_cnt == DEB_MAX) && (state_q != HOLD);
        lock_drop = !locked_s && ((state_q == RELEASE) || (state_q == RUN));

        if (!soft_s)
            deb_n = '0;
        else if (deb_cnt != DEB_MAX)
            deb_n = deb_cnt + 1'b1;

        // A held button must return low before it can trigger again.
        if (!soft_s)
            armed_n = 1'b1;
        else if (soft_trig)
            armed_n = 1'b0;

        if (lock_drop)
            lost_n = 1'b1;
        else if (clr_lock_lost)
            lost_n = 1'b0;

        if (soft_trig) begin
            state_n = HOLD;
            por_n   = POR_MAX;
            dom_n   = '1;
            lock_n  = '0;
            gap_n   = '0;
            stage_n = '0;
        end else if (lock_drop) begin
            state_n = WAIT_LOCK;
            dom_n   = '1;
            lock_n  = '0;
            gap_n   = '0;
            stage_n = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (por_cnt == '0)
                        state_n = WAIT_LOCK;
                    else
                        por_n = por_cnt - 1'b1;
                end
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        lock_n = '0;
                    end else if (lock_cnt == LOCK_MAX) begin
                        lock_n   = '0;
                        gap_n    = '0;
                        stage_n  = STAGE_W'(1);
                        dom_n[0] = 1'b0;
                        state_n  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
                    end else begin
                        lock_n = lock_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt == GAP_MAX) begin
                        gap_n = '0;
                        for (int i = 1; i < NUM_DOMAINS; i++)
                            if (stage_cnt == STAGE_W'(i))
                                dom_n[i] = 1'b0;
                        if (stage_cnt == STAGE_LAST)
                            state_n = RUN;
                        else
                            stage_n = stage_cnt + 1'b1;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    always_comb begin
        state        = state_q;
        all_ready    = (state_q == RUN);
        domain_reset = dom_q;
        lock_lost    = lost_q;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer using small parameters. Every expected value
// below is counted out by hand from the input edges.
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic       clk           = 1'b0;
    logic       reset         = 1'b1;
    logic       pll_locked    = 1'b1;
    logic       soft_rst      = 1'b0;
    logic       clr_lock_lost = 1'b0;
    logic [2:0] domain_reset;
    logic       all_ready;
    logic [1:0] state;
    logic       lock_lost;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    reset_sequencer #(
        .POR_CYCLES     (16),
        .NUM_DOMAINS    (3),
        .STAGE_GAP      (4),
        .LOCK_FILTER    (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .soft_rst     (soft_rst),
        .clr_lock_lost(clr_lock_lost),
        .domain_reset (domain_reset),
        .all_ready    (all_ready),
        .state        (state),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] dom, input logic [1:0] st,
                             input logic rdy, input logic lost);
        check({tag, ".domain_reset"}, {1'b0, domain_reset}, {1'b0, dom});
        check({tag, ".state"},        {2'b0, state},        {2'b0, st});
        check({tag, ".all_ready"},    {3'b0, all_ready},    {3'b0, rdy});
        check({tag, ".lock_lost"},    {3'b0, lock_lost},    {3'b0, lost});
    endtask

    initial begin
        // Boot with the PLL locked throughout.
        step(3);
        check_out("reset_values", 3'b111, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(15);
        check_out("hold_last", 3'b111, 2'd0, 1'b0, 1'b0);
        step(1);
        check_out("enter_wait", 3'b111, 2'd1, 1'b0, 1'b0);
        step(7);
        check_out("wait_before_release", 3'b111, 2'd1, 1'b0, 1'b0);
        step(1);
        check_out("release_d0", 3'b110, 2'd2, 1'b0, 1'b0);
        step(3);
        check_out("gap_d1_pending", 3'b110, 2'd2, 1'b0, 1'b0);
        step(1);
        check_out("release_d1", 3'b100, 2'd2, 1'b0, 1'b0);
        step(3);
        check_out("gap_d2_pending", 3'b100, 2'd2, 1'b0, 1'b0);
        step(1);
        check_out("release_d2_run", 3'b000, 2'd3, 1'b1, 1'b0);

        // Lock glitch: 5 high, 1 low, then stays high.
        reset      = 1'b1;
        pll_locked = 1'b0;
        step(2);
        reset = 1'b0;
        step(16);
        check_out("glitch_wait", 3'b111, 2'd1, 1'b0, 1'b0);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(9);
        check_out("glitch_no_release", 3'b111, 2'd1, 1'b0, 1'b0);
        step(1);
        check_out("glitch_release_d0", 3'b110, 2'd2, 1'b0, 1'b0);
        step(8);
        check_out("glitch_run", 3'b000, 2'd3, 1'b1, 1'b0);

        // Lock loss in RUN, relock, then clear the sticky flag.
        pll_locked = 1'b0;
        step(2);
        check_out("loss_sync_delay", 3'b000, 2'd3, 1'b1, 1'b0);
        step(1);
        check_out("loss_detected", 3'b111, 2'd1, 1'b0, 1'b1);
        pll_locked = 1'b1;
        step(9);
        check_out("relock_waiting", 3'b111, 2'd1, 1'b0, 1'b1);
        step(1);
        check_out("relock_d0", 3'b110, 2'd2, 1'b0, 1'b1);
        step(4);
        check_out("relock_d1", 3'b100, 2'd2, 1'b0, 1'b1);
        step(4);
        check_out("relock_run", 3'b000, 2'd3, 1'b1, 1'b1);
        clr_lock_lost = 1'b1;
        step(1);
        clr_lock_lost = 1'b0;
        check_out("lock_lost_cleared", 3'b000, 2'd3, 1'b1, 1'b0);

        // A 3-cycle soft reset pulse is too short to register.
        soft_rst = 1'b1;
        step(3);
        soft_rst = 1'b0;
        step(5);
        check_out("soft_short_ignored", 3'b000, 2'd3, 1'b1, 1'b0);

        // A 10-cycle pulse triggers 6 edges after the rise.
        soft_rst = 1'b1;
        step(5);
        check_out("soft_not_yet", 3'b000, 2'd3, 1'b1, 1'b0);
        step(1);
        check_out("soft_trigger", 3'b111, 2'd0, 1'b0, 1'b0);
        step(4);
        soft_rst = 1'b0;
        step(11);
        check_out("soft_hold_last", 3'b111, 2'd0, 1'b0, 1'b0);
        step(1);
        check_out("soft_hold_done", 3'b111, 2'd1, 1'b0, 1'b0);
        step(8);
        check_out("soft_release_d0", 3'b110, 2'd2, 1'b0, 1'b0);
        step(8);
        check_out("soft_run", 3'b000, 2'd3, 1'b1, 1'b0);

        // A held button triggers once and does not retrigger after HOLD.
        step(4);
        soft_rst = 1'b1;
        step(6);
        check_out("held_trigger", 3'b111, 2'd0, 1'b0, 1'b0);
        step(16);
        check_out("held_wait", 3'b111, 2'd1, 1'b0, 1'b0);
        step(16);
        check_out("held_run", 3'b000, 2'd3, 1'b1, 1'b0);
        step(5);
        check_out("held_no_retrigger", 3'b000, 2'd3, 1'b1, 1'b0);
        soft_rst = 1'b0;
        step(4);

        // Soft trigger and lock loss land on the same edge.
        soft_rst = 1'b1;
        step(3);
        pll_locked = 1'b0;
        step(2);
        check_out("simul_before", 3'b000, 2'd3, 1'b1, 1'b0);
        step(1);
        check_out("simul_hold_lost", 3'b111, 2'd0, 1'b0, 1'b1);
        soft_rst   = 1'b0;
        pll_locked = 1'b1;

        // Asynchronous reset in the middle of RELEASE.
        step(28);
        check_out("mid_release", 3'b100, 2'd2, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 3'b111, 2'd0, 1'b0, 1'b0);
        step(1);
        reset = 1'b0;
        step(1);
        check_out("after_async_reset", 3'b111, 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
